// File: rtl/button_conditioner_pkg.sv
// rtl/button_conditioner_pkg.sv - shared channel state encoding and default button timing
package button_conditioner_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_PRESS_CHK = 3'd1;
  localparam logic [2:0] ST_HOLD_DLY  = 3'd2;
  localparam logic [2:0] ST_HOLD_RPT  = 3'd3;
  localparam logic [2:0] ST_REL_CHK   = 3'd4;

  // Defaults assume clk_36MHz: 10 ms debounce, 300 ms first repeat, 100 ms repeat
  localparam int DEF_DEBOUNCE_CYCLES = 360000;
  localparam int DEF_REPEAT_DELAY    = 10800000;
  localparam int DEF_REPEAT_PERIOD   = 3600000;
  localparam int DEF_CNT_W           = 24;

endpackage

// File: rtl/button_conditioner_debounce_channel.sv
// rtl/button_conditioner_debounce_channel.sv - one button: 2-FF synchroniser, debounce FSM, hold-to-repeat
module debounce_channel
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic pulse,
  output logic level
);

  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RPT_LAST = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]       sync_q, sync_d;
  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             pulse_q, pulse_d;
  logic             s;

  assign s     = sync_q[1];
  assign pulse = pulse_q;
  assign level = level_q;

  always_comb begin
    sync_d  = {sync_q[0], raw};
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    pulse_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        level_d = 1'b0;
        if (s) begin
          cnt_d   = CNT_ONE;
          state_d = ST_PRESS_CHK;
        end
      end
      ST_PRESS_CHK: begin
        if (!s) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (cnt_q == DB_LAST) begin
          pulse_d = 1'b1;
          level_d = 1'b1;
          cnt_d   = '0;
          state_d = ST_HOLD_DLY;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_HOLD_DLY, ST_HOLD_RPT: begin
        if (!s) begin
          cnt_d   = CNT_ONE;
          state_d = ST_REL_CHK;
        end else if (cnt_q == ((state_q == ST_HOLD_DLY) ? DLY_LAST : RPT_LAST)) begin
          pulse_d = 1'b1;
          cnt_d   = '0;
          state_d = ST_HOLD_RPT;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_REL_CHK: begin
        // A bounce on release resumes repeating without a pulse of its own
        if (s) begin
          cnt_d   = '0;
          state_d = ST_HOLD_RPT;
        end else if (cnt_q == DB_LAST) begin
          level_d = 1'b0;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        cnt_d   = '0;
        level_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 2'b00;
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - left/right button conditioning with mutual-exclusion and enable gating
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic clk_36MHz,
  input  logic reset,
  input  logic left_raw,
  input  logic right_raw,
  input  logic enable,
  output logic left_debounced,
  output logic right_debounced,
  output logic left_level,
  output logic right_level
);

  logic left_pulse, left_level_int;
  logic right_pulse, right_level_int;

  logic left_debounced_q, left_debounced_d;
  logic right_debounced_q, right_debounced_d;
  logic left_level_q, left_level_d;
  logic right_level_q, right_level_d;

  debounce_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_PERIOD  (REPEAT_PERIOD),
    .CNT_W          (CNT_W)
  ) u_left (
    .clk  (clk_36MHz),
    .rst_n(reset),
    .raw  (left_raw),
    .pulse(left_pulse),
    .level(left_level_int)
  );

  debounce_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_PERIOD  (REPEAT_PERIOD),
    .CNT_W          (CNT_W)
  ) u_right (
    .clk  (clk_36MHz),
    .rst_n(reset),
    .raw  (right_raw),
    .pulse(right_pulse),
    .level(right_level_int)
  );

  // Holding the opposite button blocks a pulse so the ship never sees both requests
  always_comb begin
    left_debounced_d  = left_pulse & enable & ~right_level_int;
    right_debounced_d = right_pulse & enable & ~left_level_int;
    left_level_d      = left_level_int;
    right_level_d     = right_level_int;
  end

  always_ff @(posedge clk_36MHz or negedge reset) begin
    if (!reset) begin
      left_debounced_q  <= 1'b0;
      right_debounced_q <= 1'b0;
      left_level_q      <= 1'b0;
      right_level_q     <= 1'b0;
    end else begin
      left_debounced_q  <= left_debounced_d;
      right_debounced_q <= right_debounced_d;
      left_level_q      <= left_level_d;
      right_level_q     <= right_level_d;
    end
  end

  assign left_debounced  = left_debounced_q;
  assign right_debounced = right_debounced_q;
  assign left_level      = left_level_q;
  assign right_level     = right_level_q;

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - scoreboard bench for button_conditioner with small timing constants
module tb_button_conditioner;

  logic clk_36MHz = 1'b0;
  logic reset     = 1'b0;
  logic left_raw  = 1'b0;
  logic right_raw = 1'b0;
  logic enable    = 1'b1;
  logic left_debounced, right_debounced, left_level, right_level;

  typedef struct {
    int   cyc;
    int   ch;
    logic val;
  } lvl_t;

  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  logic done = 1'b0;
  int   exp_l[$];
  int   exp_r[$];
  lvl_t lv[$];

  button_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (20),
    .REPEAT_PERIOD  (8),
    .CNT_W          (24)
  ) dut (
    .clk_36MHz      (clk_36MHz),
    .reset          (reset),
    .left_raw       (left_raw),
    .right_raw      (right_raw),
    .enable         (enable),
    .left_debounced (left_debounced),
    .right_debounced(right_debounced),
    .left_level     (left_level),
    .right_level    (right_level)
  );

  always #5 clk_36MHz = ~clk_36MHz;

  always @(posedge clk_36MHz) cyc <= cyc + 1;

  // cyc == N at a negedge means edge N has just happened
  always @(negedge clk_36MHz) begin
    int   e;
    logic act;
    if (left_debounced) begin
      n_tests++;
      if (exp_l.size() == 0) begin
        n_fail++;
        $display("FAIL left_pulse: pulse at cycle %0d, required none", cyc);
      end else begin
        e = exp_l.pop_front();
        if (e != cyc) begin
          n_fail++;
          $display("FAIL left_pulse: pulse at cycle %0d, required at cycle %0d", cyc, e);
        end
      end
    end
    if (right_debounced) begin
      n_tests++;
      if (exp_r.size() == 0) begin
        n_fail++;
        $display("FAIL right_pulse: pulse at cycle %0d, required none", cyc);
      end else begin
        e = exp_r.pop_front();
        if (e != cyc) begin
          n_fail++;
          $display("FAIL right_pulse: pulse at cycle %0d, required at cycle %0d", cyc, e);
        end
      end
    end
    while (lv.size() > 0 && lv[0].cyc <= cyc) begin
      act = (lv[0].ch == 0) ? left_level : right_level;
      n_tests++;
      if (act !== lv[0].val) begin
        n_fail++;
        $display("FAIL %s_level: cycle %0d got %b, required %b",
                 (lv[0].ch == 0) ? "left" : "right", cyc, act, lv[0].val);
      end
      void'(lv.pop_front());
    end
    if (done || cyc > 5000) begin
      n_tests++;
      if (cyc > 5000) begin
        n_fail++;
        $display("FAIL timeout: cycle %0d, required finish by 5000", cyc);
      end
      n_tests++;
      if (exp_l.size() != 0) begin
        n_fail++;
        $display("FAIL left_missing: %0d pulses outstanding, required 0", exp_l.size());
      end
      n_tests++;
      if (exp_r.size() != 0) begin
        n_fail++;
        $display("FAIL right_missing: %0d pulses outstanding, required 0", exp_r.size());
      end
      n_tests++;
      if (lv.size() != 0) begin
        n_fail++;
        $display("FAIL level_missing: %0d level checks outstanding, required 0", lv.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
    end
  end

  function automatic void exp_lvl(input int c, input int ch, input logic v);
    lvl_t t;
    t.cyc = c;
    t.ch  = ch;
    t.val = v;
    lv.push_back(t);
  endfunction

  // Leaves the bench at the negedge just before edge c, so inputs set now are sampled at edge c
  task automatic goto(input int c);
    while (cyc < c - 1) @(negedge clk_36MHz);
  endtask

  initial begin
    int b;
    exp_lvl(2, 0, 1'b0);
    exp_lvl(2, 1, 1'b0);
    exp_lvl(4, 0, 1'b0);
    exp_lvl(4, 1, 1'b0);
    goto(4);
    reset = 1'b1;

    // clean press on left, 38 cycles high
    b = 10;
    exp_l.push_back(b + 6);
    exp_l.push_back(b + 26);
    exp_l.push_back(b + 34);
    exp_lvl(b + 5, 0, 1'b0);
    exp_lvl(b + 6, 0, 1'b1);
    exp_lvl(b + 6, 1, 1'b0);
    exp_lvl(b + 43, 0, 1'b1);
    exp_lvl(b + 44, 0, 1'b0);
    goto(b);
    left_raw = 1'b1;
    goto(b + 38);
    left_raw = 1'b0;

    // bouncing right press, final rise at b+4
    b = 70;
    exp_r.push_back(b + 10);
    exp_lvl(b + 9, 1, 1'b0);
    exp_lvl(b + 10, 1, 1'b1);
    exp_lvl(b + 24, 1, 1'b1);
    exp_lvl(b + 25, 1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      goto(b + i);
      right_raw = (i % 2 == 0);
    end
    goto(b + 19);
    right_raw = 1'b0;

    // 3-cycle glitch on left
    b = 110;
    exp_lvl(b + 3, 0, 1'b0);
    exp_lvl(b + 6, 0, 1'b0);
    exp_lvl(b + 8, 0, 1'b0);
    goto(b);
    left_raw = 1'b1;
    goto(b + 3);
    left_raw = 1'b0;

    // both held: left blocked while right is held, resumes after right releases
    b = 130;
    exp_l.push_back(b + 6);
    exp_l.push_back(b + 66);
    exp_l.push_back(b + 74);
    exp_lvl(b + 15, 1, 1'b0);
    exp_lvl(b + 16, 1, 1'b1);
    exp_lvl(b + 65, 1, 1'b1);
    exp_lvl(b + 66, 1, 1'b0);
    exp_lvl(b + 83, 0, 1'b1);
    exp_lvl(b + 84, 0, 1'b0);
    goto(b);
    left_raw = 1'b1;
    goto(b + 10);
    right_raw = 1'b1;
    goto(b + 60);
    right_raw = 1'b0;
    goto(b + 78);
    left_raw = 1'b0;

    // enable low across the press pulse, raised at b+10
    b = 230;
    exp_l.push_back(b + 26);
    exp_l.push_back(b + 34);
    exp_lvl(b + 6, 0, 1'b1);
    goto(b);
    enable   = 1'b0;
    left_raw = 1'b1;
    goto(b + 10);
    enable = 1'b1;
    goto(b + 38);
    left_raw = 1'b0;

    // reset asserted mid-hold, released with left still held
    b = 290;
    exp_l.push_back(b + 6);
    exp_l.push_back(b + 26);
    exp_lvl(b + 14, 0, 1'b1);
    exp_lvl(b + 15, 0, 1'b0);
    exp_lvl(b + 15, 1, 1'b0);
    exp_lvl(b + 19, 0, 1'b0);
    exp_lvl(b + 25, 0, 1'b0);
    exp_lvl(b + 26, 0, 1'b1);
    goto(b);
    left_raw = 1'b1;
    goto(b + 15);
    @(posedge clk_36MHz);
    #1 reset = 1'b0;
    goto(b + 20);
    reset = 1'b1;
    goto(b + 40);
    left_raw = 1'b0;

    goto(b + 80);
    done = 1'b1;
  end

endmodule
